// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and state types for the multiply/divide execute unit.
package riscv_pkg;

  localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider core: one quotient bit per step, XLEN steps per division.
module muldiv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            step,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            count_done
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    trial_c;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    trial_c = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (!trial_c[XLEN]) begin
      rem_d = trial_c[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= a;
      rem_q <= '0;
      dvs_q <= b;
      cnt_q <= '0;
    end else if (step) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // High while the step being taken this cycle is the final one.
  assign count_done = (cnt_q == CNT_W'(XLEN - 1));
  assign quotient   = quo_q;
  assign remainder  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: pipelined multiply, iterative divide, one-cycle done pulse.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PIPE_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int unsigned MCNT_W = 3;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   pipe_q [PIPE_D];
  logic              pipe_load_c;

  muldiv_op_e        op_c;
  logic              sgn_c;
  logic [XLEN:0]     ext_a_c, ext_b_c;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   mul_sel_c;
  logic [XLEN-1:0]   abs_a_c, abs_b_c;
  logic              div_load_c, div_step_c;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic              div_last;
  logic [XLEN-1:0]   quo_fix_c, rem_fix_c;

  // Operand conditioning from the request inputs; only sampled on the accept edge.
  always_comb begin
    op_c    = muldiv_op_e'(fun3);
    sgn_c   = !fun3[0];
    ext_a_c = {((op_c == MULH) || (op_c == MULHSU)) & op_a[XLEN-1], op_a};
    ext_b_c = {(op_c == MULH) & op_b[XLEN-1], op_b};
    prod_c  = (2*XLEN)'($signed(ext_a_c)) * (2*XLEN)'($signed(ext_b_c));
    mul_sel_c = (fun3[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    abs_a_c = (sgn_c && op_a[XLEN-1]) ? -op_a : op_a;
    abs_b_c = (sgn_c && op_b[XLEN-1]) ? -op_b : op_b;
    quo_fix_c = neg_q_q ? -div_quo : div_quo;
    rem_fix_c = neg_r_q ? -div_rem : div_rem;
  end

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (div_load_c),
    .a          (abs_a_c),
    .b          (abs_b_c),
    .step       (div_step_c),
    .quotient   (div_quo),
    .remainder  (div_rem),
    .count_done (div_last)
  );

  // Next-state and output logic; flush overrides everything except the result.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    mcnt_d      = mcnt_q;
    is_rem_d    = is_rem_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    pipe_load_c = 1'b0;
    div_load_c  = 1'b0;
    div_step_c  = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!fun3[2]) begin
              if (MUL_LAT == 1) begin
                result_d = mul_sel_c;
                done_d   = 1'b1;
              end else begin
                state_d     = S_MUL;
                mcnt_d      = MCNT_W'(1);
                pipe_load_c = 1'b1;
              end
            end else if (op_b == '0) begin
              result_d = fun3[1] ? op_a : '1;
              done_d   = 1'b1;
            end else if (sgn_c && (op_a == XMIN) && (&op_b)) begin
              result_d = fun3[1] ? '0 : op_a;
              done_d   = 1'b1;
            end else begin
              state_d    = S_DIV;
              div_load_c = 1'b1;
              is_rem_d   = fun3[1];
              neg_q_d    = sgn_c & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              neg_r_d    = sgn_c & op_a[XLEN-1];
            end
          end
        end
        S_MUL: begin
          mcnt_d = mcnt_q + MCNT_W'(1);
          if (mcnt_q == MCNT_W'(MUL_LAT - 1)) begin
            result_d = pipe_q[PIPE_D-1];
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_DIV: begin
          div_step_c = 1'b1;
          if (div_last) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = is_rem_q ? rem_fix_c : quo_fix_c;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mcnt_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      mcnt_q   <= mcnt_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  // Product delay line; the result register forms the final stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
    end else begin
      if (pipe_load_c) pipe_q[0] <= mul_sel_c;
      for (int unsigned i = 1; i < PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_LAT=2).
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  fun3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int lat, bcnt;
  logic saw;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .fun3    (fun3),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request in cycle T; returns positioned in cycle T+1.
  task automatic issue(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    fun3  = f;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle T+1; returns in the done cycle with its offset from T.
  task automatic wait_done(output int l, output int bc);
    l  = -1;
    bc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done === 1'b1) begin
        l = k;
        break;
      end
      if (busy === 1'b1) bc++;
      tick();
    end
  endtask

  task automatic run(input string tag, input muldiv_op_e f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    issue(f, a, b);
    wait_done(lat, bcnt);
    chk({tag, "_lat"},  32'(lat),  32'(exp_lat));
    chk({tag, "_res"},  result,    exp_res);
    chk({tag, "_busy"}, 32'(bcnt), 32'(exp_lat - 1));
    chk({tag, "_bdone"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    reset_n = 1'b1;
    tick();

    run("mul",    MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    tick();
    chk("done_pulse", {31'b0, done}, 32'd0);
    run("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    run("div",    DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem",    REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("divu",   DIVU,   32'hFFFF_FFFF, 32'd7,         32'h2492_4924, 34);
    run("remu",   REMU,   32'hFFFF_FFFF, 32'd7,         32'd3,         34);
    run("divz",   DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run("remz",   REM,    32'd100,       32'd0,         32'd100,       1);
    run("divovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run("divneg", DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run("remneg", REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         34);

    // Flush at T+10 of a divide.
    tick();
    issue(DIV, 32'd5000, 32'd3);
    saw = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (done === 1'b1) saw = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_early_done", {31'b0, saw},  32'd0);
    chk("flush_busy",       {31'b0, busy}, 32'd0);
    chk("flush_done",       {31'b0, done}, 32'd0);
    chk("flush_result",     result,        32'd2);
    tick();
    run("mul_after_flush", MUL, 32'd5, 32'd6, 32'd30, 2);
    saw = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) saw = 1'b1;
    end
    chk("flush_no_late_done", {31'b0, saw}, 32'd0);

    // Start held high through a divide, then accepted in the done cycle.
    start = 1'b1;
    fun3  = DIVU;
    op_a  = 32'd1000;
    op_b  = 32'd10;
    tick();
    fun3 = MUL;
    op_a = 32'd3;
    op_b = 32'd4;
    wait_done(lat, bcnt);
    chk("held_lat",  32'(lat),  32'd34);
    chk("held_busy", 32'(bcnt), 32'd33);
    chk("held_res",  result,    32'd100);
    tick();
    start = 1'b0;
    chk("b2b_done_gap", {31'b0, done}, 32'd0);
    chk("b2b_busy",     {31'b0, busy}, 32'd1);
    tick();
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_res",  result,        32'd12);

    // Asynchronous reset in the middle of a divide.
    tick();
    issue(DIVU, 32'd1000, 32'd10);
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy",   {31'b0, busy}, 32'd0);
    chk("arst_done",   {31'b0, done}, 32'd0);
    chk("arst_result", result,        32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
